acc_buffer_param: RTL and testbench
===================================

// Module: acc_buffer_param
// PURPOSE
//  Parametrised, pipelined accumulator buffer: DATA_NUM signed lanes per entry, RAM_DEPTH entries.
//  Sits after the systolic array columns; sums partial products across K-tiles, then drains to the unified buffer.
//  Adds over the prior accumulator: async reset, write pipeline with RAW forwarding, saturation/overflow flags,
//  clear-on-read, and a full-memory clear sweep.
// PARAMETERS
//  DATA_SIZE  20           lane width (bits, two's complement)
//  DATA_NUM   16           lanes per entry
//  RAM_DEPTH  16           entries; AW = clog2(RAM_DEPTH), min 1
//  SATURATE   1            1: clamp lane sums to signed range; 0: wrap
//  W          DATA_NUM*DATA_SIZE (derived, localparam)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  rst_n        in   1    asynchronous active-low reset
//  wea          in   1    write request (port A)
//  acc_en       in   1    1: entry += dina per lane; 0: entry = dina
//  addra        in   AW   write address
//  dina         in   W    write data, lane i = dina[i*DATA_SIZE +: DATA_SIZE]
//  enb          in   1    read request (port B)
//  rd_clr       in   1    with enb: zero the entry after reading it
//  addrb        in   AW   read address
//  doutb        out  W    read data
//  doutb_valid  out  1    1-cycle pulse, doutb valid
//  clr_start    in   1    start full-memory clear sweep
//  busy         out  1    sweep in progress; wea/enb/rd_clr ignored
//  ovf          out  DATA_NUM  sticky per-lane overflow
//  ovf_clr      in   1    clears ovf
// BEHAVIOUR
//  Reset: doutb=0, doutb_valid=0, ovf=0, busy=0, FSM=IDLE, P1 invalid. Memory not reset (BRAM); undefined.
//  Write pipe: accepted when wea & !busy. Edge 0 captures addr/data/acc_en + old = bram[addra] into P1.
//   Edge 1: P1 result written to bram. Commit latency 2 edges; throughput 1/cycle.
//  Forwarding: incoming write or read with addr == P1.addr & P1 valid uses P1 result, not bram.
//   Back-to-back accumulates to one address must sum exactly (no lost update).
//  Read: enb & !busy samples at edge; next cycle doutb = entry incl. all writes accepted on EARLIER edges;
//   write accepted on the same edge is NOT visible. doutb holds when no read.
//  rd_clr: if !wea, clear is issued as pass-through write of 0 to addrb through P1.
//   if wea & addra==addrb: write forced pass-through (acc onto 0); if wea & addra!=addrb: rd_clr ignored.
//  Arithmetic: per-lane signed DATA_SIZE+1 sum. Overflow = sum outside DATA_SIZE signed range.
//   SATURATE=1 clamps to +2^(DS-1)-1 / -2^(DS-1); SATURATE=0 keeps low DS bits. Either way sets ovf[i]
//   on the commit edge. Pass-through never overflows. ovf_clr with new overflow same edge: set wins.
//  FSM IDLE -> CLEAR on clr_start (busy=1 next cycle); pending P1 commits before sweep.
//   CLEAR writes 0 to addr 0..RAM_DEPTH-1, one per cycle, then -> IDLE, busy=0 after the last write.
//   clr_start while busy ignored. doutb_valid=0 throughout CLEAR. rst_n low mid-sweep: IDLE, memory partial.
//  Address counter wraps only at RAM_DEPTH-1 (non-power-of-2 depth supported).
// STRUCTURE
//  acc_pkg: DATA_SIZE/DATA_NUM defaults, state enum {IDLE, CLEAR}, lane sat-min/max constants.
//  Sub-module acc_lane_add: one lane add/pass/saturate + overflow bit; instantiated DATA_NUM times.
//  Top holds bram, P1 register, forwarding muxes, read register, clear FSM and counter.
// TESTING
//  1 Pass-through: write addr3 lanes=5, read addr3 two cycles later -> doutb lanes=5, doutb_valid 1 cycle.
//  2 RAW: wea acc on addr2 with 1 for 4 consecutive cycles after pass 0 -> read gives 4, no lost update.
//  3 Saturation: lane0 = 524287, acc +1 -> 524287 (SATURATE=1), ovf[0]=1; SATURATE=0 -> -524288, ovf[0]=1.
//  4 Clear-on-read: entry=7, enb+rd_clr -> doutb=7; re-read next cycle -> 0; same-addr wea acc 3 -> 3.
//  5 Sweep: fill all entries, clr_start -> busy exactly RAM_DEPTH cycles, wea ignored, all reads then 0.
//  6 Reset: rst_n low mid-sweep and mid-write -> outputs 0, busy 0, FSM IDLE, ovf 0 immediately (async).

Source files
------------

// File: rtl/acc_pkg.sv
//------------------------------------------------------------------------------
// Module  : acc_pkg
// Brief   : Shared defaults, clear-FSM state encoding and lane saturation limits
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package acc_pkg;
  localparam int DATA_SIZE_DEF = 20;
  localparam int DATA_NUM_DEF  = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic signed [DATA_SIZE_DEF-1:0] LANE_MAX = {1'b0, {(DATA_SIZE_DEF-1){1'b1}}};
  localparam logic signed [DATA_SIZE_DEF-1:0] LANE_MIN = {1'b1, {(DATA_SIZE_DEF-1){1'b0}}};
endpackage

`default_nettype wire

// File: rtl/acc_buffer_param_lane_add.sv
//------------------------------------------------------------------------------
// Module  : acc_lane_add
// Brief   : One signed lane: pass-through or add, with clamp/wrap and overflow
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acc_lane_add #(
  parameter int DATA_SIZE = 20,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 acc_en,
  input  logic [DATA_SIZE-1:0] old_val,
  input  logic [DATA_SIZE-1:0] add_val,
  output logic [DATA_SIZE-1:0] result,
  output logic                 ovf
);
  localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  logic [DATA_SIZE:0] sum;

  always_comb begin
    sum = {old_val[DATA_SIZE-1], old_val} + {add_val[DATA_SIZE-1], add_val};
    // the two top bits of the widened sum disagree exactly when it leaves range
    ovf = acc_en & (sum[DATA_SIZE] ^ sum[DATA_SIZE-1]);
    if (!acc_en) begin
      result = add_val;
    end else if (ovf && SATURATE) begin
      result = sum[DATA_SIZE] ? SAT_MIN : SAT_MAX;
    end else begin
      result = sum[DATA_SIZE-1:0];
    end
  end
endmodule

`default_nettype wire

// File: rtl/acc_buffer_param.sv
//------------------------------------------------------------------------------
// Module  : acc_buffer_param
// Brief   : Pipelined multi-lane accumulator buffer with forwarding and clear sweep
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acc_buffer_param
  import acc_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DATA_NUM  = DATA_NUM_DEF,
  parameter int RAM_DEPTH = 16,
  parameter bit SATURATE  = 1'b1,
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int W  = DATA_NUM * DATA_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wea,
  input  logic                acc_en,
  input  logic [AW-1:0]       addra,
  input  logic [W-1:0]        dina,
  input  logic                enb,
  input  logic                rd_clr,
  input  logic [AW-1:0]       addrb,
  output logic [W-1:0]        doutb,
  output logic                doutb_valid,
  input  logic                clr_start,
  output logic                busy,
  output logic [DATA_NUM-1:0] ovf,
  input  logic                ovf_clr
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  logic [W-1:0] bram [RAM_DEPTH];

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                p1_valid_q, p1_valid_d;
  logic                p1_acc_q, p1_acc_d;
  logic [AW-1:0]       p1_addr_q, p1_addr_d;
  logic [W-1:0]        p1_data_q, p1_data_d;
  logic [W-1:0]        p1_old_q, p1_old_d;
  logic [W-1:0]        doutb_q, doutb_d;
  logic                doutb_valid_q, doutb_valid_d;
  logic [DATA_NUM-1:0] ovf_q, ovf_d;

  logic [W-1:0]        p1_res;
  logic [DATA_NUM-1:0] lane_ovf;
  logic                wr_fire, rd_fire, clr_issue, fwd_wr, fwd_rd;

  for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
    acc_lane_add #(
      .DATA_SIZE (DATA_SIZE),
      .SATURATE  (SATURATE)
    ) u_lane (
      .acc_en  (p1_acc_q),
      .old_val (p1_old_q[i*DATA_SIZE +: DATA_SIZE]),
      .add_val (p1_data_q[i*DATA_SIZE +: DATA_SIZE]),
      .result  (p1_res[i*DATA_SIZE +: DATA_SIZE]),
      .ovf     (lane_ovf[i])
    );
  end

  always_comb begin
    wr_fire   = wea & ~busy_q;
    // reads are refused on the sweep start edge so doutb_valid stays low throughout
    rd_fire   = enb & ~busy_q & ~((state_q == IDLE) & clr_start);
    clr_issue = rd_fire & rd_clr & (~wea | (addra == addrb));

    p1_valid_d = wr_fire | clr_issue;
    p1_addr_d  = wr_fire ? addra : addrb;
    p1_data_d  = wr_fire ? dina : '0;
    p1_acc_d   = wr_fire & acc_en & ~clr_issue;

    fwd_wr   = p1_valid_q & (p1_addr_q == p1_addr_d);
    p1_old_d = fwd_wr ? p1_res : bram[p1_addr_d];

    fwd_rd        = p1_valid_q & (p1_addr_q == addrb);
    doutb_d       = rd_fire ? (fwd_rd ? p1_res : bram[addrb]) : doutb_q;
    doutb_valid_d = rd_fire;

    ovf_d = (ovf_clr ? '0 : ovf_q) | (p1_valid_q ? lane_ovf : '0);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      p1_valid_q    <= 1'b0;
      p1_acc_q      <= 1'b0;
      p1_addr_q     <= '0;
      p1_data_q     <= '0;
      p1_old_q      <= '0;
      doutb_q       <= '0;
      doutb_valid_q <= 1'b0;
      ovf_q         <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      p1_valid_q    <= p1_valid_d;
      p1_acc_q      <= p1_acc_d;
      p1_addr_q     <= p1_addr_d;
      p1_data_q     <= p1_data_d;
      p1_old_q      <= p1_old_d;
      doutb_q       <= doutb_d;
      doutb_valid_q <= doutb_valid_d;
      ovf_q         <= ovf_d;
    end
  end

  // a write caught in P1 on the sweep start edge is zeroed by the sweep anyway
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      bram[cnt_q] <= '0;
    end else if (p1_valid_q) begin
      bram[p1_addr_q] <= p1_res;
    end
  end

  assign doutb       = doutb_q;
  assign doutb_valid = doutb_valid_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_acc_buffer_param.sv
//------------------------------------------------------------------------------
// Module  : tb_acc_buffer_param
// Brief   : Directed self-checking bench for acc_buffer_param (clamp and wrap)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acc_buffer_param;
  localparam int DS    = 20;
  localparam int DN    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = DS * DN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wea, acc_en, enb, rd_clr, clr_start, ovf_clr;
  logic [AW-1:0] addra, addrb;
  logic [W-1:0]  dina;
  logic [W-1:0]  doutb, doutb_w;
  logic          doutb_valid, doutb_valid_w, busy, busy_w;
  logic [DN-1:0] ovf, ovf_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_buffer_param #(.DATA_SIZE(DS), .DATA_NUM(DN), .RAM_DEPTH(DEPTH), .SATURATE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wea(wea), .acc_en(acc_en), .addra(addra), .dina(dina),
    .enb(enb), .rd_clr(rd_clr), .addrb(addrb), .doutb(doutb), .doutb_valid(doutb_valid),
    .clr_start(clr_start), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  acc_buffer_param #(.DATA_SIZE(DS), .DATA_NUM(DN), .RAM_DEPTH(DEPTH), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .wea(wea), .acc_en(acc_en), .addra(addra), .dina(dina),
    .enb(enb), .rd_clr(rd_clr), .addrb(addrb), .doutb(doutb_w), .doutb_valid(doutb_valid_w),
    .clr_start(clr_start), .busy(busy_w), .ovf(ovf_w), .ovf_clr(ovf_clr)
  );

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < DN; i++) r[i*DS +: DS] = DS'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] set_lane(input logic [W-1:0] d, input int i, input int v);
    logic [W-1:0] r;
    r = d;
    r[i*DS +: DS] = DS'(v);
    return r;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    wea = 1'b0; acc_en = 1'b0; enb = 1'b0; rd_clr = 1'b0; clr_start = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic acc, input logic [W-1:0] d);
    wea = 1'b1; acc_en = acc; addra = a; dina = d;
    cyc();
    drive_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic clr);
    enb = 1'b1; rd_clr = clr; addrb = a;
    cyc();
    drive_idle();
  endtask

  task automatic test_reset;
    drive_idle();
    addra = '0; addrb = '0; dina = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (doutb !== '0 || doutb_valid !== 1'b0 || busy !== 1'b0 || ovf !== '0) begin
      errors++;
      $display("FAIL reset_state doutb=%h valid=%b busy=%b ovf=%h required all zero", doutb, doutb_valid, busy, ovf);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_passthrough;
    do_write(4'd3, 1'b0, fill(5));
    cyc();
    do_read(4'd3, 1'b0);
    checks++;
    if (doutb !== fill(5) || doutb_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_read doutb=%h valid=%b required %h valid=1", doutb, doutb_valid, fill(5));
    end
    cyc();
    checks++;
    if (doutb !== fill(5) || doutb_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_hold doutb=%h valid=%b required %h valid=0", doutb, doutb_valid, fill(5));
    end
  endtask

  task automatic test_raw;
    do_write(4'd2, 1'b0, fill(0));
    repeat (4) do_write(4'd2, 1'b1, fill(1));
    // fifth accumulate on the same edge as the read must not be visible
    wea = 1'b1; acc_en = 1'b1; addra = 4'd2; dina = fill(1);
    enb = 1'b1; addrb = 4'd2;
    cyc();
    drive_idle();
    checks++;
    if (doutb !== fill(4)) begin
      errors++;
      $display("FAIL raw_four doutb=%h required %h", doutb, fill(4));
    end
    do_read(4'd2, 1'b0);
    checks++;
    if (doutb !== fill(5) || doutb_w !== fill(5)) begin
      errors++;
      $display("FAIL raw_five doutb=%h wrap=%h required %h", doutb, doutb_w, fill(5));
    end
  endtask

  task automatic test_saturation;
    logic [W-1:0] d0, d1, exp_sat, exp_wrap;
    d0 = set_lane(set_lane(set_lane(fill(0), 0, 524287), 1, -524288), 2, 100);
    d1 = set_lane(set_lane(set_lane(fill(0), 0, 1), 1, -1), 2, 23);
    exp_sat  = set_lane(set_lane(set_lane(fill(0), 0, 524287), 1, -524288), 2, 123);
    exp_wrap = set_lane(set_lane(set_lane(fill(0), 0, -524288), 1, 524287), 2, 123);
    ovf_clr = 1'b1;
    cyc();
    drive_idle();
    checks++;
    if (ovf !== 16'h0000 || ovf_w !== 16'h0000) begin
      errors++;
      $display("FAIL ovf_clear0 ovf=%h wrap=%h required 0000", ovf, ovf_w);
    end
    do_write(4'd5, 1'b0, d0);
    do_write(4'd5, 1'b1, d1);
    checks++;
    if (ovf !== 16'h0000) begin
      errors++;
      $display("FAIL ovf_before_commit ovf=%h required 0000", ovf);
    end
    cyc();
    checks++;
    if (ovf !== 16'h0003 || ovf_w !== 16'h0003) begin
      errors++;
      $display("FAIL ovf_commit ovf=%h wrap=%h required 0003", ovf, ovf_w);
    end
    do_read(4'd5, 1'b0);
    checks++;
    if (doutb !== exp_sat) begin
      errors++;
      $display("FAIL sat_value doutb=%h required %h", doutb, exp_sat);
    end
    checks++;
    if (doutb_w !== exp_wrap) begin
      errors++;
      $display("FAIL wrap_value doutb=%h required %h", doutb_w, exp_wrap);
    end
    ovf_clr = 1'b1;
    cyc();
    drive_idle();
    checks++;
    if (ovf !== 16'h0000 || ovf_w !== 16'h0000) begin
      errors++;
      $display("FAIL ovf_clear1 ovf=%h wrap=%h required 0000", ovf, ovf_w);
    end
    do_write(4'd6, 1'b0, set_lane(fill(0), 0, 524287));
    do_write(4'd6, 1'b1, set_lane(fill(0), 0, 1));
    ovf_clr = 1'b1;
    cyc();
    drive_idle();
    checks++;
    if (ovf !== 16'h0001 || ovf_w !== 16'h0001) begin
      errors++;
      $display("FAIL ovf_set_wins ovf=%h wrap=%h required 0001", ovf, ovf_w);
    end
    ovf_clr = 1'b1;
    cyc();
    drive_idle();
  endtask

  task automatic test_clear_on_read;
    do_write(4'd4, 1'b0, fill(7));
    cyc(); cyc();
    do_read(4'd4, 1'b1);
    checks++;
    if (doutb !== fill(7)) begin
      errors++;
      $display("FAIL rdclr_first doutb=%h required %h", doutb, fill(7));
    end
    do_read(4'd4, 1'b0);
    checks++;
    if (doutb !== fill(0)) begin
      errors++;
      $display("FAIL rdclr_reread doutb=%h required 0", doutb);
    end
    do_write(4'd4, 1'b0, fill(7));
    cyc(); cyc();
    wea = 1'b1; acc_en = 1'b1; addra = 4'd4; dina = fill(3);
    enb = 1'b1; rd_clr = 1'b1; addrb = 4'd4;
    cyc();
    drive_idle();
    checks++;
    if (doutb !== fill(7)) begin
      errors++;
      $display("FAIL rdclr_same_read doutb=%h required %h", doutb, fill(7));
    end
    do_read(4'd4, 1'b0);
    checks++;
    if (doutb !== fill(3)) begin
      errors++;
      $display("FAIL rdclr_same_acc doutb=%h required %h", doutb, fill(3));
    end
    do_write(4'd7, 1'b0, fill(9));
    cyc(); cyc();
    wea = 1'b1; acc_en = 1'b0; addra = 4'd8; dina = fill(2);
    enb = 1'b1; rd_clr = 1'b1; addrb = 4'd7;
    cyc();
    drive_idle();
    do_read(4'd7, 1'b0);
    checks++;
    if (doutb !== fill(9)) begin
      errors++;
      $display("FAIL rdclr_ignored doutb=%h required %h", doutb, fill(9));
    end
    do_read(4'd8, 1'b0);
    checks++;
    if (doutb !== fill(2)) begin
      errors++;
      $display("FAIL rdclr_other_write doutb=%h required %h", doutb, fill(2));
    end
  endtask

  task automatic test_sweep;
    int n;
    int bad;
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 1'b0, fill(i + 1));
    cyc(); cyc();
    do_read(4'd15, 1'b0);
    checks++;
    if (doutb !== fill(16)) begin
      errors++;
      $display("FAIL sweep_fill doutb=%h required %h", doutb, fill(16));
    end
    clr_start = 1'b1;
    cyc();
    drive_idle();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      checks++;
      if (doutb_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_valid cycle=%0d valid=%b required 0", n, doutb_valid);
      end
      wea = 1'b1; acc_en = 1'b0; addra = 4'd0; dina = fill(99);
      enb = 1'b1; addrb = 4'd0;
      clr_start = (n == 3);
      cyc();
      n++;
    end
    drive_idle();
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL sweep_busy_len cycles=%0d required %0d", n, DEPTH);
    end
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_restart busy=%b required 0", busy);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i), 1'b0);
      if (doutb !== fill(0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_zero nonzero_entries=%0d required 0", bad);
    end
  endtask

  task automatic test_async_reset;
    do_write(4'd9, 1'b0, set_lane(fill(0), 0, 524287));
    do_write(4'd9, 1'b1, set_lane(fill(0), 0, 1));
    cyc();
    do_read(4'd9, 1'b0);
    clr_start = 1'b1;
    cyc();
    drive_idle();
    cyc(); cyc();
    checks++;
    if (busy !== 1'b1 || ovf !== 16'h0001 || doutb !== set_lane(fill(0), 0, 524287)) begin
      errors++;
      $display("FAIL pre_reset busy=%b ovf=%h doutb=%h required busy=1 ovf=0001", busy, ovf, doutb);
    end
    wea = 1'b1; acc_en = 1'b0; addra = 4'd2; dina = fill(11);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (doutb !== '0 || doutb_valid !== 1'b0 || busy !== 1'b0 || ovf !== '0 || ovf_w !== '0) begin
      errors++;
      $display("FAIL async_reset doutb=%h valid=%b busy=%b ovf=%h required all zero", doutb, doutb_valid, busy, ovf);
    end
    drive_idle();
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b required 0", busy);
    end
    do_write(4'd2, 1'b0, fill(11));
    cyc();
    do_read(4'd2, 1'b0);
    checks++;
    if (doutb !== fill(11)) begin
      errors++;
      $display("FAIL post_reset_write doutb=%h required %h", doutb, fill(11));
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_raw();
    test_saturation();
    test_clear_on_read();
    test_sweep();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
